mcpu_control_fsm: RTL and testbench

Multi-cycle control state machine for the MCPU datapath. It consumes the opcode/funct fields of the instruction register and the ALU zero flag. Each cycle it drives every register enable, write enable and mux select in the datapath: PC, IR, A, B, BEN, regfile, memory, and the ALU A/B, PCSrc, RegDst and MemToReg muxes. It also keeps a retired-instruction counter.

---
 rtl/mcpu_ctrl_pkg.sv | 93 +++++++++
 rtl/mcpu_ctrl_decode.sv | 103 ++++++++++
 rtl/mcpu_control_fsm.sv | 116 +++++++++++
 tb/tb_mcpu_control_fsm.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/mcpu_ctrl_pkg.sv
// MCPU control package: state enum, opcode/funct constants, ALU ops and mux selects.
// MCPU_CTRL_JR_EN adds the JR state and makes R-type funct 0x08 legal.
package mcpu_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_EXEC_I,
        S_WB_R,
        S_WB_I,
        S_MEM_ADDR,
        S_MEM_RD,
        S_MEM_WB,
        S_MEM_WR,
        S_BRANCH,
        S_JUMP
`ifdef MCPU_CTRL_JR_EN
        , S_JR
`endif
    } state_e;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_XORI = 6'h0E;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_XOR  = 3'd2;
    localparam logic [2:0] ALU_SLT  = 3'd3;
    localparam logic [2:0] ALU_AND  = 3'd4;
    localparam logic [2:0] ALU_NAND = 3'd5;
    localparam logic [2:0] ALU_NOR  = 3'd6;
    localparam logic [2:0] ALU_OR   = 3'd7;

    localparam logic [1:0] SRC_A_PC   = 2'd0;
    localparam logic [1:0] SRC_A_REG  = 2'd1;
    localparam logic [1:0] SRC_A_BEN  = 2'd2;
    localparam logic [1:0] SRC_A_ZERO = 2'd3;

    localparam logic [1:0] SRC_B_IMM_SH = 2'd0;
    localparam logic [1:0] SRC_B_IMM    = 2'd1;
    localparam logic [1:0] SRC_B_REG    = 2'd2;
    localparam logic [1:0] SRC_B_FOUR   = 2'd3;

    localparam logic [1:0] PC_SRC_BRANCH = 2'd0;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd1;
    localparam logic [1:0] PC_SRC_ALU    = 2'd2;
    localparam logic [1:0] PC_SRC_ALUREG = 2'd3;

    typedef struct packed {
        logic       pc_we;
        logic       ir_we;
        logic       a_we;
        logic       b_we;
        logic       ben_we;
        logic       mem_we;
        logic       reg_we;
        logic       mem_in;
        logic       dst;
        logic       reg_in;
        logic       jal;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_src;
        logic       beq_bne;
        logic       illegal;
    } ctrl_t;

    // States whose exit into FETCH retires an instruction.
    function automatic logic is_retiring(input state_e s);
        case (s)
            S_WB_R, S_WB_I, S_MEM_WB, S_MEM_WR, S_BRANCH, S_JUMP: return 1'b1;
`ifdef MCPU_CTRL_JR_EN
            S_JR: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mcpu_ctrl_decode.sv
// Combinational state/opcode/funct -> control-word decode for the MCPU controller.
// MCPU_CTRL_JR_EN makes funct 0x08 legal in EXEC_R and decodes the JR state.
module mcpu_ctrl_decode
    import mcpu_ctrl_pkg::*;
(
    input  state_e      state_i,
    input  logic [5:0]  opcode_i,
    input  logic [5:0]  funct_i,
    input  logic        zero_i,
    output ctrl_t       ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.ir_we     = 1'b1;
                ctrl_o.alu_src_a = SRC_A_PC;
                ctrl_o.alu_src_b = SRC_B_FOUR;
                ctrl_o.alu_op    = ALU_ADD;
                ctrl_o.pc_src    = PC_SRC_ALU;
                ctrl_o.pc_we     = 1'b1;
            end
            S_DECODE: begin
                ctrl_o.a_we      = 1'b1;
                ctrl_o.b_we      = 1'b1;
                ctrl_o.ben_we    = 1'b1;
                ctrl_o.alu_src_a = SRC_A_PC;
                ctrl_o.alu_src_b = SRC_B_IMM_SH;
                ctrl_o.alu_op    = ALU_ADD;
                case (opcode_i)
                    OP_R, OP_ADDI, OP_XORI, OP_LW, OP_SW,
                    OP_BEQ, OP_BNE, OP_J, OP_JAL: ctrl_o.illegal = 1'b0;
                    default:                      ctrl_o.illegal = 1'b1;
                endcase
            end
            S_EXEC_R: begin
                ctrl_o.alu_src_a = SRC_A_REG;
                ctrl_o.alu_src_b = SRC_B_REG;
                case (funct_i)
                    FN_ADD:  ctrl_o.alu_op = ALU_ADD;
                    FN_SUB:  ctrl_o.alu_op = ALU_SUB;
                    FN_SLT:  ctrl_o.alu_op = ALU_SLT;
`ifdef MCPU_CTRL_JR_EN
                    FN_JR:   ctrl_o.alu_op = ALU_ADD;
`endif
                    default: ctrl_o.illegal = 1'b1;
                endcase
            end
            S_EXEC_I: begin
                ctrl_o.alu_src_a = SRC_A_REG;
                ctrl_o.alu_src_b = SRC_B_IMM;
                ctrl_o.alu_op    = (opcode_i == OP_XORI) ? ALU_XOR : ALU_ADD;
            end
            S_WB_R, S_WB_I: begin
                ctrl_o.reg_we = 1'b1;
                ctrl_o.reg_in = 1'b1;
                ctrl_o.dst    = (state_i == S_WB_I);
            end
            S_MEM_ADDR: begin
                ctrl_o.alu_src_a = SRC_A_REG;
                ctrl_o.alu_src_b = SRC_B_IMM;
                ctrl_o.alu_op    = ALU_ADD;
            end
            S_MEM_RD: ctrl_o.mem_in = 1'b1;
            S_MEM_WB: begin
                ctrl_o.reg_we = 1'b1;
                ctrl_o.reg_in = 1'b0;
                ctrl_o.dst    = 1'b1;
            end
            S_MEM_WR: begin
                ctrl_o.mem_in = 1'b1;
                ctrl_o.mem_we = 1'b1;
            end
            S_BRANCH: begin
                // opcode[0] distinguishes BNE from BEQ; the PC write is the only zero-dependent output.
                ctrl_o.alu_src_a = SRC_A_REG;
                ctrl_o.alu_src_b = SRC_B_REG;
                ctrl_o.alu_op    = ALU_SUB;
                ctrl_o.beq_bne   = opcode_i[0];
                ctrl_o.pc_src    = PC_SRC_BRANCH;
                ctrl_o.pc_we     = zero_i ^ opcode_i[0];
            end
            S_JUMP: begin
                ctrl_o.pc_src = PC_SRC_JUMP;
                ctrl_o.pc_we  = 1'b1;
                ctrl_o.reg_we = (opcode_i == OP_JAL);
                ctrl_o.jal    = (opcode_i == OP_JAL);
            end
`ifdef MCPU_CTRL_JR_EN
            S_JR: begin
                ctrl_o.alu_src_a = SRC_A_REG;
                ctrl_o.alu_src_b = SRC_B_REG;
                ctrl_o.alu_op    = ALU_ADD;
                ctrl_o.pc_src    = PC_SRC_ALU;
                ctrl_o.pc_we     = 1'b1;
            end
`endif
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/mcpu_control_fsm.sv
// MCPU multi-cycle control FSM: state register, next-state logic and retired-instruction counter.
// MCPU_CTRL_JR_EN enables the JR (R-type funct 0x08) path.
module mcpu_control_fsm
    import mcpu_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        zero,
    output logic        pc_we,
    output logic        ir_we,
    output logic        a_we,
    output logic        b_we,
    output logic        ben_we,
    output logic        mem_we,
    output logic        reg_we,
    output logic        mem_in,
    output logic        dst,
    output logic        reg_in,
    output logic        jal,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [2:0]  alu_op,
    output logic [1:0]  pc_src,
    output logic        beq_bne,
    output logic        illegal,
    output logic [31:0] instr_count
);

    state_e      state_q, state_d;
    logic [31:0] count_q, count_d;
    ctrl_t       ctrl, ctrl_out;

    mcpu_ctrl_decode u_decode (
        .state_i  (state_q),
        .opcode_i (opcode),
        .funct_i  (funct),
        .zero_i   (zero),
        .ctrl_o   (ctrl)
    );

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_R:             state_d = S_EXEC_R;
                    OP_ADDI, OP_XORI: state_d = S_EXEC_I;
                    OP_LW, OP_SW:     state_d = S_MEM_ADDR;
                    OP_BEQ, OP_BNE:   state_d = S_BRANCH;
                    OP_J, OP_JAL:     state_d = S_JUMP;
                    default:          state_d = S_FETCH;
                endcase
            end
            S_EXEC_R: begin
                if (ctrl.illegal)
                    state_d = S_FETCH;
`ifdef MCPU_CTRL_JR_EN
                else if (funct == FN_JR)
                    state_d = S_JR;
`endif
                else
                    state_d = S_WB_R;
            end
            S_EXEC_I:   state_d = S_WB_I;
            S_MEM_ADDR: state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   state_d = S_MEM_WB;
            default:    state_d = S_FETCH;
        endcase
    end

    always_comb begin
        count_d = count_q;
        if (is_retiring(state_q))
            count_d = count_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Reset is synchronous, so the outputs are gated directly to keep every enable low while it is held.
    always_comb begin
        ctrl_out    = reset ? '0 : ctrl;
        instr_count = reset ? '0 : count_q;
    end

    always_comb begin
        pc_we     = ctrl_out.pc_we;
        ir_we     = ctrl_out.ir_we;
        a_we      = ctrl_out.a_we;
        b_we      = ctrl_out.b_we;
        ben_we    = ctrl_out.ben_we;
        mem_we    = ctrl_out.mem_we;
        reg_we    = ctrl_out.reg_we;
        mem_in    = ctrl_out.mem_in;
        dst       = ctrl_out.dst;
        reg_in    = ctrl_out.reg_in;
        jal       = ctrl_out.jal;
        alu_src_a = ctrl_out.alu_src_a;
        alu_src_b = ctrl_out.alu_src_b;
        alu_op    = ctrl_out.alu_op;
        pc_src    = ctrl_out.pc_src;
        beq_bne   = ctrl_out.beq_bne;
        illegal   = ctrl_out.illegal;
    end

endmodule

// File: tb/tb_mcpu_control_fsm.sv
// Scoreboard bench for mcpu_control_fsm: per-instruction expected control-word sequences are queued
// by the stimulus and compared cycle by cycle on the falling edge. Honours MCPU_CTRL_JR_EN.
module tb_mcpu_control_fsm;

`ifdef MCPU_CTRL_JR_EN
    localparam bit JR_EN = 1'b1;
`else
    localparam bit JR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, zero;
    logic [5:0]  opcode, funct;
    logic        pc_we, ir_we, a_we, b_we, ben_we, mem_we, reg_we, mem_in, dst, reg_in, jal;
    logic [1:0]  alu_src_a, alu_src_b, pc_src;
    logic [2:0]  alu_op;
    logic        beq_bne, illegal;
    logic [31:0] instr_count;

    typedef struct packed {
        logic       pc_we, ir_we, a_we, b_we, ben_we, mem_we, reg_we, mem_in, dst, reg_in, jal;
        logic [1:0] sa;
        logic [1:0] sb;
        logic [2:0] op;
        logic [1:0] pcs;
        logic       bb;
        logic       ill;
    } cw_t;

    typedef struct {
        cw_t         cw;
        bit          op_dc;
        logic [31:0] cnt;
        string       name;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        cur;
    cw_t         act, mask;
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    logic [31:0] cnt_model;

    always #5 clk = ~clk;

    mcpu_control_fsm dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .pc_we(pc_we), .ir_we(ir_we), .a_we(a_we), .b_we(b_we), .ben_we(ben_we),
        .mem_we(mem_we), .reg_we(reg_we), .mem_in(mem_in), .dst(dst), .reg_in(reg_in),
        .jal(jal), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_src(pc_src), .beq_bne(beq_bne), .illegal(illegal), .instr_count(instr_count)
    );

    assign act = {pc_we, ir_we, a_we, b_we, ben_we, mem_we, reg_we, mem_in, dst, reg_in, jal,
                  alu_src_a, alu_src_b, alu_op, pc_src, beq_bne, illegal};

    // Monitor: one expected entry per clock cycle, compared away from the rising edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            cur  = exp_q.pop_front();
            mask = '1;
            if (cur.op_dc) mask.op = '0;
            n_checks++;
            if ((act & mask) == (cur.cw & mask)) n_pass++;
            else $display("FAIL %s ctrl: got %h, expected %h", cur.name, act & mask, cur.cw & mask);
            n_checks++;
            if (instr_count == cur.cnt) n_pass++;
            else $display("FAIL %s instr_count: got %0d, expected %0d", cur.name, instr_count, cur.cnt);
        end
    end

    task automatic push(input cw_t c, input bit dc, input string nm, input logic [31:0] cnt);
        exp_t e;
        e.cw = c; e.op_dc = dc; e.name = nm; e.cnt = cnt;
        exp_q.push_back(e);
    endtask

    function automatic cw_t cw_fetch();
        cw_t c = '0;
        c.ir_we = 1'b1; c.sb = 2'd3; c.pcs = 2'd2; c.pc_we = 1'b1;
        return c;
    endfunction

    function automatic bit legal_opcode(input logic [5:0] op);
        return op inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h0E, 6'h02, 6'h03};
    endfunction

    // Reference model: the cycle-by-cycle control words an instruction must produce.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z);
        cw_t         c;
        int unsigned n = 0;
        bit          retire = 1'b1;
        bit          dc = 1'b0;
        string       nm;
        opcode = op; funct = fn; zero = z;
        nm = $sformatf("op%02h/fn%02h/z%0d", op, fn, z);
        push(cw_fetch(), 1'b0, {nm, ":fetch"}, cnt_model); n++;
        c = '0;
        c.a_we = 1'b1; c.b_we = 1'b1; c.ben_we = 1'b1;
        c.ill = !legal_opcode(op);
        push(c, 1'b0, {nm, ":decode"}, cnt_model); n++;
        if (c.ill) begin
            retire = 1'b0;
        end else begin
            c = '0;
            case (op)
                6'h00: begin
                    c.sa = 2'd1; c.sb = 2'd2;
                    if      (fn == 6'h20) c.op = 3'd0;
                    else if (fn == 6'h22) c.op = 3'd1;
                    else if (fn == 6'h2A) c.op = 3'd3;
                    else if (fn == 6'h08 && JR_EN) c.op = 3'd0;
                    else begin c.ill = 1'b1; dc = 1'b1; end
                    push(c, dc, {nm, ":exec_r"}, cnt_model); n++;
                    c = '0;
                    if (dc) retire = 1'b0;
                    else if (fn == 6'h08) begin
                        c.sa = 2'd1; c.sb = 2'd2; c.op = 3'd0; c.pcs = 2'd2; c.pc_we = 1'b1;
                        push(c, 1'b0, {nm, ":jr"}, cnt_model); n++;
                    end else begin
                        c.reg_we = 1'b1; c.reg_in = 1'b1; c.dst = 1'b0;
                        push(c, 1'b0, {nm, ":wb_r"}, cnt_model); n++;
                    end
                end
                6'h08, 6'h0E: begin
                    c.sa = 2'd1; c.sb = 2'd1; c.op = (op == 6'h0E) ? 3'd2 : 3'd0;
                    push(c, 1'b0, {nm, ":exec_i"}, cnt_model); n++;
                    c = '0; c.reg_we = 1'b1; c.reg_in = 1'b1; c.dst = 1'b1;
                    push(c, 1'b0, {nm, ":wb_i"}, cnt_model); n++;
                end
                6'h23, 6'h2B: begin
                    c.sa = 2'd1; c.sb = 2'd1; c.op = 3'd0;
                    push(c, 1'b0, {nm, ":mem_addr"}, cnt_model); n++;
                    c = '0;
                    if (op == 6'h23) begin
                        c.mem_in = 1'b1;
                        push(c, 1'b0, {nm, ":mem_rd"}, cnt_model); n++;
                        c = '0; c.reg_we = 1'b1; c.reg_in = 1'b0; c.dst = 1'b1;
                        push(c, 1'b0, {nm, ":mem_wb"}, cnt_model); n++;
                    end else begin
                        c.mem_in = 1'b1; c.mem_we = 1'b1;
                        push(c, 1'b0, {nm, ":mem_wr"}, cnt_model); n++;
                    end
                end
                6'h04, 6'h05: begin
                    c.sa = 2'd1; c.sb = 2'd2; c.op = 3'd1; c.bb = op[0]; c.pcs = 2'd0;
                    c.pc_we = z ^ op[0];
                    push(c, 1'b0, {nm, ":branch"}, cnt_model); n++;
                end
                default: begin
                    c.pcs = 2'd1; c.pc_we = 1'b1;
                    c.reg_we = (op == 6'h03); c.jal = (op == 6'h03);
                    push(c, 1'b0, {nm, ":jump"}, cnt_model); n++;
                end
            endcase
        end
        if (retire) cnt_model = cnt_model + 32'd1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // LW abandoned by a one-cycle reset while in MEM_RD.
    task automatic run_lw_reset();
        cw_t c;
        opcode = 6'h23; funct = 6'h00; zero = 1'b0;
        push(cw_fetch(), 1'b0, "lw_rst:fetch", cnt_model);
        c = '0; c.a_we = 1'b1; c.b_we = 1'b1; c.ben_we = 1'b1;
        push(c, 1'b0, "lw_rst:decode", cnt_model);
        c = '0; c.sa = 2'd1; c.sb = 2'd1;
        push(c, 1'b0, "lw_rst:mem_addr", cnt_model);
        push('0, 1'b0, "lw_rst:reset", 32'd0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        cnt_model = '0;
    endtask

    logic [5:0] rop, rfn;
    initial begin
        reset = 1'b1; opcode = '0; funct = '0; zero = 1'b0;
        cnt_model = '0;
        @(posedge clk);
        #1;
        push('0, 1'b0, "reset0", 32'd0);
        push('0, 1'b0, "reset1", 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        run_instr(6'h00, 6'h20, 1'b0);
        run_instr(6'h23, 6'h00, 1'b0);
        run_instr(6'h2B, 6'h00, 1'b0);
        run_instr(6'h04, 6'h00, 1'b1);
        run_instr(6'h05, 6'h00, 1'b1);
        run_instr(6'h03, 6'h00, 1'b0);
        run_instr(6'h3F, 6'h00, 1'b0);
        run_instr(6'h00, 6'h08, 1'b0);
        run_instr(6'h00, 6'h3F, 1'b0);
        run_instr(6'h08, 6'h11, 1'b0);
        run_instr(6'h0E, 6'h11, 1'b0);
        run_instr(6'h02, 6'h00, 1'b0);
        run_lw_reset();
        run_instr(6'h00, 6'h22, 1'b0);

        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 11))
                0:  rop = 6'h00;
                1:  rop = 6'h00;
                2:  rop = 6'h23;
                3:  rop = 6'h2B;
                4:  rop = 6'h04;
                5:  rop = 6'h05;
                6:  rop = 6'h08;
                7:  rop = 6'h0E;
                8:  rop = 6'h02;
                9:  rop = 6'h03;
                default: rop = 6'($urandom_range(0, 63));
            endcase
            case ($urandom_range(0, 4))
                0: rfn = 6'h20;
                1: rfn = 6'h22;
                2: rfn = 6'h2A;
                3: rfn = 6'h08;
                default: rfn = 6'($urandom_range(0, 63));
            endcase
            run_instr(rop, rfn, 1'($urandom_range(0, 1)));
        end

        repeat (2) @(posedge clk);
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d expected cycles left, required 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
